// File: rtl/count_dispatch.sv
// count_dispatch: FIFO-buffered job scheduler in front of the W-bit ones/zeros count engine.
// Optional WAIT-state watchdog (limit TMO cycles) is enabled by defining COUNT_TIMEOUT_EN.
module count_dispatch #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int TMO   = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_data,
   input  logic [1:0]   req_sel,
   output logic [W-1:0] eng_a,
   output logic [1:0]   eng_sel,
   output logic         eng_start,
   input  logic         eng_done,
   input  logic [W-1:0] eng_cnt,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_cnt,
   output logic [1:0]   rsp_sel,
   output logic         rsp_err,
   output logic [15:0]  jobs_done
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO < 1) begin : g_param_check
      $error("count_dispatch: DEPTH must be a power of 2 >= 2 and TMO >= 1");
   end

   state_t        state, state_nxt;

   logic [W-1:0]  fifo_data [DEPTH];
   logic [1:0]    fifo_sel  [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fill;
   logic          full, empty, push, pop;
   logic [W-1:0]  head_data;
   logic [1:0]    head_sel;
   logic          head_legal;

   logic          wait_first;
   logic          capture, timeout;
   logic          load_eng, load_rsp, count_inc;
   logic [W-1:0]  rsp_cnt_d;
   logic [1:0]    rsp_sel_d;
   logic          rsp_err_d;

   // ---------------- request FIFO ----------------
   assign full       = (fill == (AW+1)'(DEPTH));
   assign empty      = (fill == '0);
   assign req_ready  = !full;
   assign push       = req_valid && !full;
   assign head_data  = fifo_data[rd_ptr];
   assign head_sel   = fifo_sel[rd_ptr];
   assign head_legal = ^head_sel;

   // NOTE: storage array has no reset; only the pointers and fill level define FIFO contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= req_data;
         fifo_sel[wr_ptr]  <= req_sel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   // ---------------- completion detect ----------------
   // The engine may still show done from the previous job during the first WAIT cycle.
   assign capture = (state == WAIT) && eng_done && !wait_first;

`ifdef COUNT_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                wait_cnt <= '0;
      else if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + CW'(1);
   end

   assign timeout = (state == WAIT) && !capture && (wait_cnt == CW'(TMO - 1));
`else
   assign timeout = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = head_legal ? ISSUE : RESP;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (capture || timeout) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      pop       = 1'b0;
      load_eng  = 1'b0;
      load_rsp  = 1'b0;
      count_inc = 1'b0;
      rsp_cnt_d = '0;
      rsp_sel_d = eng_sel;
      rsp_err_d = 1'b0;
      rsp_valid = (state == RESP);
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_legal) begin
                  load_eng = 1'b1;
               end else begin
                  load_rsp  = 1'b1;
                  rsp_sel_d = head_sel;
                  rsp_err_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (capture) begin
               load_rsp  = 1'b1;
               rsp_cnt_d = eng_cnt;
            end else if (timeout) begin
               load_rsp  = 1'b1;
               rsp_cnt_d = '1;
               rsp_err_d = 1'b1;
            end
         end
         RESP:    count_inc = rsp_ready;
         default: ;
      endcase
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_a      <= '0;
         eng_sel    <= '0;
         eng_start  <= 1'b0;
         wait_first <= 1'b0;
         rsp_cnt    <= '0;
         rsp_sel    <= '0;
         rsp_err    <= 1'b0;
         jobs_done  <= '0;
      end else begin
         eng_start  <= (state_nxt == ISSUE);
         wait_first <= (state == ISSUE);
         if (load_eng) begin
            eng_a   <= head_data;
            eng_sel <= head_sel;
         end
         if (load_rsp) begin
            rsp_cnt <= rsp_cnt_d;
            rsp_sel <= rsp_sel_d;
            rsp_err <= rsp_err_d;
         end
         if (count_inc) jobs_done <= jobs_done + 16'd1;
      end
   end

endmodule

// File: tb/tb_count_dispatch.sv
// Self-checking bench for count_dispatch: directed cases plus randomized traffic against a
// job-level reference model; an engine responder replays stale done to probe the capture rule.
module tb_count_dispatch;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_data;
   logic [1:0]   req_sel;
   logic [W-1:0] eng_a;
   logic [1:0]   eng_sel;
   logic         eng_start;
   logic         eng_done;
   logic [W-1:0] eng_cnt;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_cnt;
   logic [1:0]   rsp_sel;
   logic         rsp_err;
   logic [15:0]  jobs_done;

   count_dispatch #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_sel   (req_sel),
      .eng_a     (eng_a),
      .eng_sel   (eng_sel),
      .eng_start (eng_start),
      .eng_done  (eng_done),
      .eng_cnt   (eng_cnt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_cnt   (rsp_cnt),
      .rsp_sel   (rsp_sel),
      .rsp_err   (rsp_err),
      .jobs_done (jobs_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic [1:0]   sel;
      logic [W-1:0] cnt;
      logic         err;
      logic         xuse;
      logic [W-1:0] xcnt;
      logic         hang;
   } job_t;

   job_t        exp_q[$];     // responses expected, in push order
   job_t        eng_q[$];     // legal jobs expected to reach the engine, in push order
   logic [15:0] model_done = '0;
   int          checks     = 0;
   int          failures   = 0;
   int          starts     = 0;
   int          rsp_seen   = 0;
   int          lat_fix    = 0;   // 0 = random engine latency 1..4
   int          rdy_mode   = 2;   // 0 random, 1 held low, 2 held high

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] count_bits(input logic [W-1:0] d, input logic [1:0] s);
      int n = 0;
      for (int i = 0; i < W; i++) if (d[i] == (s == 2'b10)) n++;
      return W'(n);
   endfunction

   function automatic job_t make_job(input logic [W-1:0] d, input logic [1:0] s, input logic xuse,
                                     input logic [W-1:0] xc, input logic hang);
      job_t j;
      j.data = d; j.sel = s; j.xuse = xuse; j.xcnt = xc; j.hang = hang;
      if (s != 2'b10 && s != 2'b01) begin j.cnt = '0;              j.err = 1'b1; end
      else if (hang)                begin j.cnt = '1;              j.err = 1'b1; end
      else if (xuse)                begin j.cnt = xc;              j.err = 1'b0; end
      else                          begin j.cnt = count_bits(d, s); j.err = 1'b0; end
      return j;
   endfunction

   // Called at a falling edge; returns at a falling edge after the job was accepted.
   task automatic push(input logic [W-1:0] d, input logic [1:0] s, input logic xuse,
                       input logic [W-1:0] xc, input logic hang, output int stalls);
      job_t j;
      j = make_job(d, s, xuse, xc, hang);
      req_valid = 1'b1; req_data = d; req_sel = s; stalls = 0;
      while (!req_ready && stalls < 400) begin @(negedge clk); stalls++; end
      if (!req_ready) begin
         checks++; failures++;
         $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, expected 1", stalls);
      end else begin
         exp_q.push_back(j);
         if (s == 2'b10 || s == 2'b01) eng_q.push_back(j);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
      check({name, "_valid"}, rsp_valid, 1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      check({name, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic wait_start(input string name, input int s0);
      int n = 0;
      while (starts == s0 && n < 300) begin @(negedge clk); n++; end
      check({name, "_start_seen"}, (starts != s0), 1);
   endtask

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   // Compare process plus engine responder, both on the falling edge.
   initial begin
      job_t         ej, rj;
      int           eng_drop, eng_left;
      logic         eng_busy, hold_chk, prev_hs, prev_start;
      logic [W-1:0] lat_a, hold_cnt;
      logic [1:0]   lat_sel, hold_sel;
      logic         hold_err;
      eng_done = 1'b0; eng_cnt = '0;
      eng_drop = 0; eng_left = 0; eng_busy = 1'b0;
      hold_chk = 1'b0; prev_hs = 1'b0; prev_start = 1'b0;
      lat_a = '0; lat_sel = '0; hold_cnt = '0; hold_sel = '0; hold_err = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            eng_done = 1'b0; eng_drop = 0; eng_busy = 1'b0;
            hold_chk = 1'b0; prev_hs = 1'b0; prev_start = 1'b0;
         end else begin
            check("jobs_done", jobs_done, model_done);
            if (prev_hs) check("rsp_valid_drop", rsp_valid, 0);
            if (hold_chk) begin
               check("hold_valid", rsp_valid, 1);
               check("hold_cnt", rsp_cnt, hold_cnt);
               check("hold_sel", rsp_sel, hold_sel);
               check("hold_err", rsp_err, hold_err);
            end
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_rsp: rsp_valid=1 with cnt=%h, expected no response", rsp_cnt);
               end else if (rsp_ready) begin
                  rj = exp_q.pop_front();
                  check("rsp_cnt", rsp_cnt, rj.cnt);
                  check("rsp_sel", rsp_sel, rj.sel);
                  check("rsp_err", rsp_err, rj.err);
                  model_done++;
                  rsp_seen++;
               end
            end
            hold_chk = rsp_valid && !rsp_ready;
            hold_cnt = rsp_cnt; hold_sel = rsp_sel; hold_err = rsp_err;
            prev_hs  = rsp_valid && rsp_ready;
            if (prev_start) check("start_single_cycle", eng_start, 0);
            prev_start = eng_start;
            if (eng_busy || eng_drop != 0) begin
               check("eng_a_stable", eng_a, lat_a);
               check("eng_sel_stable", eng_sel, lat_sel);
            end
            if (eng_start) begin
               starts++;
               if (eng_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_start: eng_start=1 with eng_a=%h, expected no start", eng_a);
                  ej = make_job(eng_a, eng_sel, 1'b0, '0, 1'b0);
               end else begin
                  ej = eng_q.pop_front();
                  check("start_a", eng_a, ej.data);
                  check("start_sel", eng_sel, ej.sel);
               end
               lat_a = eng_a; lat_sel = eng_sel;
               eng_drop = 2;   // keep the previous done visible through the first WAIT cycle
            end else if (eng_drop != 0) begin
               eng_drop--;
               if (eng_drop == 0) begin
                  eng_done = 1'b0;
                  eng_cnt  = W'($urandom);
                  eng_busy = 1'b1;
                  eng_left = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
               end
            end else if (eng_busy) begin
               eng_left--;
               if (eng_left == 0) begin
                  eng_busy = 1'b0;
                  if (!ej.hang) begin
                     eng_done = 1'b1;
                     eng_cnt  = ej.xuse ? ej.xcnt : count_bits(lat_a, lat_sel);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           st, s0, r0, n;
      int           r;
      logic [W-1:0] xword, xcnt, d;
      logic [1:0]   s;
      rst = 1'b1; req_valid = 1'b0; req_data = '0; req_sel = '0;
      #1 rst = 1'b0;
      #2;
      check("rst_eng_a", eng_a, 0);
      check("rst_eng_sel", eng_sel, 0);
      check("rst_eng_start", eng_start, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_cnt", rsp_cnt, 0);
      check("rst_rsp_sel", rsp_sel, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_jobs_done", jobs_done, 0);
      check("rst_req_ready", req_ready, 1);
      #11 rst = 1'b1;   // released at 14 ns
      @(negedge clk);

      // Ones count
      s0 = starts;
      push(8'b0000_1011, 2'b10, 1'b0, '0, 1'b0, st);
      wait_valid("ones");
      check("ones_cnt", rsp_cnt, 3);
      check("ones_sel", rsp_sel, 2'b10);
      check("ones_err", rsp_err, 0);
      @(negedge clk);
      check("ones_jobs_done", jobs_done, 1);
      check("ones_start_count", starts - s0, 1);

      // Zeros count under back-pressure
      rdy_mode = 1;
      @(negedge clk);
      push(8'b0100_0010, 2'b01, 1'b0, '0, 1'b0, st);
      wait_valid("zeros");
      for (int i = 0; i < 5; i++) begin
         check("zeros_cnt_held", rsp_cnt, 6);
         check("zeros_valid_held", rsp_valid, 1);
         @(negedge clk);
      end
      rdy_mode = 2;
      @(negedge clk);
      check("zeros_handshake", {rsp_valid, rsp_ready}, 2'b11);
      @(negedge clk);
      check("zeros_valid_fall", rsp_valid, 0);
      check("zeros_jobs_done", jobs_done, 2);

      // FIFO full while the engine is busy
      lat_fix = 20;
      s0 = starts;
      push(8'hA5, 2'b10, 1'b0, '0, 1'b0, st);
      wait_start("full", s0);
      push(8'h0F, 2'b10, 1'b0, '0, 1'b0, st);
      push(8'hF0, 2'b01, 1'b0, '0, 1'b0, st);
      push(8'h33, 2'b10, 1'b0, '0, 1'b0, st);
      push(8'hFF, 2'b01, 1'b0, '0, 1'b0, st);
      check("full_req_ready", req_ready, 0);
      push(8'h81, 2'b10, 1'b0, '0, 1'b0, st);
      check("full_fifth_stalled", (st > 0), 1);
      lat_fix = 0;
      wait_drain("full");
      @(negedge clk);
      check("full_jobs_done", jobs_done, 8);

      // Illegal selects bypass the engine
      s0 = starts;
      push(8'h5A, 2'b00, 1'b0, '0, 1'b0, st);
      wait_valid("illegal");
      check("illegal_cnt", rsp_cnt, 0);
      check("illegal_err", rsp_err, 1);
      check("illegal_sel", rsp_sel, 2'b00);
      @(negedge clk);
      push(8'hC3, 2'b11, 1'b0, '0, 1'b0, st);
      wait_drain("illegal");
      @(negedge clk);
      check("illegal_jobs_done", jobs_done, 10);
      check("illegal_no_start", starts - s0, 0);

      // Unknown bits pass through untouched
      xword = 8'b1010_x001;
      xcnt  = 8'b0000_0x10;
      push(xword, 2'b10, 1'b1, xcnt, 1'b0, st);
      wait_valid("xprop");
      check("xprop_cnt", rsp_cnt, xcnt);
      @(negedge clk);
      check("xprop_jobs_done", jobs_done, 11);

      // Reset while a job sits in WAIT and another in the FIFO
      lat_fix = 30;
      s0 = starts;
      push(8'h3C, 2'b10, 1'b0, '0, 1'b0, st);
      wait_start("midrst", s0);
      push(8'hC3, 2'b01, 1'b0, '0, 1'b0, st);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      exp_q.delete(); eng_q.delete(); model_done = '0; lat_fix = 0;
      #1;
      check("midrst_eng_a", eng_a, 0);
      check("midrst_eng_sel", eng_sel, 0);
      check("midrst_eng_start", eng_start, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_rsp_cnt", rsp_cnt, 0);
      check("midrst_rsp_sel", rsp_sel, 0);
      check("midrst_rsp_err", rsp_err, 0);
      check("midrst_jobs_done", jobs_done, 0);
      check("midrst_req_ready", req_ready, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      s0 = starts; r0 = rsp_seen;
      repeat (20) @(negedge clk);
      check("midrst_no_start", starts - s0, 0);
      check("midrst_no_rsp", rsp_seen - r0, 0);
      check("midrst_jobs_after", jobs_done, 0);
      check("midrst_ready_after", req_ready, 1);

      // Randomized traffic
      rdy_mode = 0;
      for (int k = 0; k < 60; k++) begin
         d = W'($urandom);
         r = $urandom_range(0, 9);
         s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01;
         push(d, s, 1'b0, '0, 1'b0, st);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain("random");
      repeat (2) @(negedge clk);
      check("random_jobs_done", jobs_done, 60);
      rdy_mode = 2;

`ifdef COUNT_TIMEOUT_EN
      // Engine never reports done: the watchdog must abort the job
      s0 = starts;
      push(8'h77, 2'b10, 1'b0, '0, 1'b1, st);
      n = 0;
      while (!eng_start && n < 100) begin @(negedge clk); n++; end
      check("tmo_start_seen", eng_start, 1);
      n = 0;
      while (!rsp_valid && n < 4 * TMO) begin @(negedge clk); n++; end
      check("tmo_latency", n, TMO + 1);
      check("tmo_cnt", rsp_cnt, 8'hFF);
      check("tmo_err", rsp_err, 1);
      @(negedge clk);
      check("tmo_jobs_done", jobs_done, 61);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
